acc_datapath: RTL and testbench
===============================

// Module: acc_datapath
// PURPOSE
//   Accumulator datapath driven by the 4-phase accumulator controller's sel/en strobes.
//   - Sums accepted input samples into a frame accumulator.
//   - en commits the running sum and sample count to a one-deep output slot.
//   - sel clears the accumulator to start a new frame.
//   - Sits between the sample source (valid/ready) and the result consumer (valid/ready).
// PARAMETERS
//   DW   8   input sample width (unsigned)
//   AW   12  accumulator/result width (AW >= DW)
//   CW   4   sample-count width
//   SAT  1   1: accumulator saturates at 2^AW-1; 0: wraps modulo 2^AW
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   rst        in   1   synchronous reset, active-high
//   sel        in   1   frame restart strobe from controller
//   en         in   1   commit strobe from controller
//   in_valid   in   1   sample source has data
//   in_data    in   DW  sample value
//   in_ready   out  1   datapath accepts sample this cycle
//   out_valid  out  1   result slot full
//   out_ready  in   1   consumer takes result this cycle
//   acc_out    out  AW  committed sum
//   cnt_out    out  CW  committed sample count (saturating)
//   ovf_out    out  1   committed frame overflowed (sum exceeded 2^AW-1)
//   overrun    out  1   1-cycle pulse: commit lost because slot was full and not draining
// BEHAVIOUR
//   Reset: acc=0, cnt=0, ovf=0, out_valid=0, acc_out=0, cnt_out=0, ovf_out=0, overrun=0.
//     rst wins over every other input; rst mid-frame discards the partial sum and any pending result.
//   Definitions: accept = in_valid & in_ready; hold = out_valid & ~out_ready.
//   in_ready = ~hold (combinational); sample source stalls while an undelivered result blocks the slot.
//   Accumulator next value (registered, one-cycle latency):
//     sel & accept   -> acc=in_data, cnt=1, ovf=0   (sample belongs to new frame)
//     sel & ~accept  -> acc=0, cnt=0, ovf=0
//     ~sel & accept  -> acc=acc+in_data using an AW+1-bit sum:
//       - carry out sets ovf (sticky until sel/rst).
//       - SAT=1: acc=2^AW-1 on carry; SAT=0: acc=low AW bits.
//       - cnt+=1, saturating at 2^CW-1.
//     else           -> hold
//   Commit (en): captures the registered pre-update acc/cnt/ovf into the slot.
//     A sample accepted the same cycle is added to the live acc, not the committed value.
//     en & sel same cycle: commit old frame, then clear.
//   Output slot FSM, states EMPTY (out_valid=0) and FULL (out_valid=1):
//     EMPTY: en             -> FULL, load slot
//     FULL : out_ready & en -> FULL, load new result (back-to-back, no bubble)
//     FULL : out_ready & ~en-> EMPTY
//     FULL : ~out_ready & en-> FULL, slot unchanged, overrun=1 for one cycle
//     FULL : ~out_ready & ~en-> FULL, acc_out/cnt_out/ovf_out stable
//   Slot outputs change only on load or reset.
//   Results are tolerated unconsumed indefinitely; only a new en against a held slot raises overrun.
//   With the controller's 4-cycle period (en phase then sel phase), each frame gets 3 sample
//     slots + boundary; design makes no assumption of that period.
// TESTING
//   1 rst=1 with in_valid=1, in_data=8'h55 -> all outputs 0 on next edge, acc stays 0.
//   2 sel, then accept 3,4,5, en, out_ready=1 -> acc_out=12, cnt_out=3, ovf_out=0, out_valid 1 cycle.
//   3 SAT=1, AW=8: accept 200,100 then en -> acc_out=255, ovf_out=1; same with SAT=0 -> acc_out=44, ovf_out=1.
//   4 out_ready=0 after a commit, second en -> overrun pulse, acc_out holds first value, in_ready=0 until out_ready=1.
//   5 en&sel&accept(in_data=7) same cycle with acc=20 -> acc_out=20; live acc=7, cnt=1.
//   6 Continuous controller strobes with out_ready=1 and in_valid=1, in_data=1: every commit reports cnt_out equal to samples since previous sel; no overrun.

Source files
------------

// File: rtl/acc_datapath.sv
// ----------------------------------------------------------------------------
// acc_datapath
//   Frame accumulator sitting between a valid/ready sample source and a
//   valid/ready result consumer, steered by controller strobes:
//     sel : restart the frame (the sample accepted this cycle opens the new frame)
//     en  : commit the pre-update sum/count/overflow into a one-deep result slot
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   sel, en               controller strobes
//   in_valid/in_ready     sample handshake, in_data = unsigned DW-bit sample
//   out_valid/out_ready   result handshake
//   acc_out, cnt_out      committed sum and (saturating) sample count
//   ovf_out               committed frame carried out of AW bits at least once
//   overrun               one-cycle pulse: commit dropped against a held slot
// ----------------------------------------------------------------------------
module acc_datapath #(
    parameter int DW  = 8,
    parameter int AW  = 12,
    parameter int CW  = 4,
    parameter bit SAT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc_out,
    output logic [CW-1:0] cnt_out,
    output logic          ovf_out,
    output logic          overrun
);

    typedef struct packed {
        logic [AW-1:0] acc;
        logic [CW-1:0] cnt;
        logic          ovf;
    } frame_t;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_e;

    frame_t      frame_q, frame_d;
    frame_t      slot_q;
    slot_state_e state_q;
    logic        overrun_q;

    logic        hold;
    logic        accept;
    logic [AW:0] sum;

    // The source stalls only while an undelivered result blocks the slot.
    assign hold     = (state_q == S_FULL) && !out_ready;
    assign in_ready = !hold;
    assign accept   = in_valid && in_ready;

    // One extra bit so the carry out of the accumulator is visible.
    assign sum = {1'b0, frame_q.acc} + (AW+1)'(in_data);

    always_comb begin
        frame_d = frame_q;
        if (sel) begin
            frame_d = '0;
            if (accept) begin
                frame_d.acc = AW'(in_data);
                frame_d.cnt = CW'(1);
            end
        end else if (accept) begin
            frame_d.ovf = frame_q.ovf | sum[AW];
            frame_d.acc = (SAT && sum[AW]) ? {AW{1'b1}} : sum[AW-1:0];
            frame_d.cnt = (frame_q.cnt == {CW{1'b1}}) ? frame_q.cnt : frame_q.cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) frame_q <= '0;
        else     frame_q <= frame_d;
    end

    // Result slot. It loads frame_q (the value before this cycle's update), so
    // en together with sel reports the finishing frame while the clear proceeds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            slot_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                S_EMPTY: begin
                    if (en) begin
                        state_q <= S_FULL;
                        slot_q  <= frame_q;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        if (en) slot_q  <= frame_q;   // back-to-back reload
                        else    state_q <= S_EMPTY;
                    end else begin
                        overrun_q <= en;              // slot kept, new result lost
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign acc_out   = slot_q.acc;
    assign cnt_out   = slot_q.cnt;
    assign ovf_out   = slot_q.ovf;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_acc_datapath.sv
module tb_acc_datapath;

    logic       clk = 1'b0;
    logic       rst, sel, en, in_valid, out_ready;
    logic [7:0] in_data;

    // dut_s: AW=8 saturating, dut_w: AW=8 wrapping; both see identical stimulus.
    logic       in_ready_s, out_valid_s, ovf_s, ovr_s;
    logic [7:0] acc_s;
    logic [3:0] cnt_s;
    logic       in_ready_w, out_valid_w, ovf_w, ovr_w;
    logic [7:0] acc_w;
    logic [3:0] cnt_w;

    acc_datapath #(.DW(8), .AW(8), .CW(4), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .acc_out(acc_s), .cnt_out(cnt_s), .ovf_out(ovf_s), .overrun(ovr_s));

    acc_datapath #(.DW(8), .AW(8), .CW(4), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .acc_out(acc_w), .cnt_out(cnt_w), .ovf_out(ovf_w), .overrun(ovr_w));

    always #5 clk = ~clk;

    logic [14:0] vec_s, vec_w;
    assign vec_s = {out_valid_s, acc_s, cnt_s, ovf_s, ovr_s};
    assign vec_w = {out_valid_w, acc_w, cnt_w, ovf_w, ovr_w};

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model (integer arithmetic) ----------------
    int macc[2];
    int mcnt;
    bit movf[2];
    bit mfull;
    int sacc[2];
    int scnt;
    bit sovf[2];
    bit movr;

    function automatic logic [14:0] mk(bit v, int a, int c, bit o, bit r);
        return {v, 8'(a), 4'(c), o, r};
    endfunction

    function automatic logic [14:0] exp_vec(int v);
        return {mfull, 8'(sacc[v]), 4'(scnt), sovf[v], movr};
    endfunction

    function automatic void model_step();
        bit hold, ok;
        int s;
        if (rst) begin
            macc = '{0, 0}; movf = '{0, 0}; sacc = '{0, 0}; sovf = '{0, 0};
            mcnt = 0; scnt = 0; mfull = 0; movr = 0;
            return;
        end
        hold = mfull && !out_ready;
        ok   = in_valid && !hold;
        movr = en && hold;
        if (en && !hold) begin
            sacc = macc; scnt = mcnt; sovf = movf;
        end
        mfull = en || hold;
        if (sel) begin
            for (int v = 0; v < 2; v++) begin
                macc[v] = ok ? int'(in_data) : 0;
                movf[v] = 0;
            end
            mcnt = ok ? 1 : 0;
        end else if (ok) begin
            for (int v = 0; v < 2; v++) begin
                s = macc[v] + int'(in_data);
                if (s > 255) begin
                    movf[v] = 1;
                    macc[v] = (v == 0) ? 255 : s - 256;
                end else begin
                    macc[v] = s;
                end
            end
            mcnt = (mcnt < 15) ? mcnt + 1 : 15;
        end
    endfunction

    task automatic apply(input bit s, input bit e, input bit iv, input int d, input bit r);
        rst = 1'b0; sel = s; en = e; in_valid = iv; in_data = 8'(d); out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply(0, 1, 1, 8'h55, 0);
        rst = 1'b1;
        tick();
        n_cmp++; if (vec_s !== 15'd0) begin n_err++; $display("FAIL reset_s got %h want 0", vec_s); end
        n_cmp++; if (vec_w !== 15'd0) begin n_err++; $display("FAIL reset_w got %h want 0", vec_w); end
        n_cmp++; if (in_ready_s !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready_s); end
        // acc must have stayed 0 despite in_valid during reset
        apply(0, 1, 0, 0, 0);
        tick();
        n_cmp++; if (vec_s !== mk(1, 0, 0, 0, 0)) begin n_err++; $display("FAIL reset_acc got %h want %h", vec_s, mk(1, 0, 0, 0, 0)); end
        apply(0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_basic();
        apply(1, 0, 0, 0, 1); tick();
        apply(0, 0, 1, 3, 1); tick();
        apply(0, 0, 1, 4, 1); tick();
        apply(0, 0, 1, 5, 1); tick();
        apply(0, 1, 0, 0, 1); tick();
        n_cmp++; if (vec_s !== mk(1, 12, 3, 0, 0)) begin n_err++; $display("FAIL basic_s got %h want %h", vec_s, mk(1, 12, 3, 0, 0)); end
        n_cmp++; if (vec_w !== mk(1, 12, 3, 0, 0)) begin n_err++; $display("FAIL basic_w got %h want %h", vec_w, mk(1, 12, 3, 0, 0)); end
        apply(0, 0, 0, 0, 1); tick();
        n_cmp++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b want 0", out_valid_s); end
    endtask

    task automatic test_ovf();
        apply(1, 0, 0, 0, 1); tick();
        apply(0, 0, 1, 200, 1); tick();
        apply(0, 0, 1, 100, 1); tick();
        apply(0, 1, 0, 0, 1); tick();
        n_cmp++; if (vec_s !== mk(1, 255, 2, 1, 0)) begin n_err++; $display("FAIL ovf_sat got %h want %h", vec_s, mk(1, 255, 2, 1, 0)); end
        n_cmp++; if (vec_w !== mk(1, 44, 2, 1, 0)) begin n_err++; $display("FAIL ovf_wrap got %h want %h", vec_w, mk(1, 44, 2, 1, 0)); end
        // sel clears the sticky flag
        apply(1, 0, 0, 0, 1); tick();
        apply(0, 1, 0, 0, 1); tick();
        n_cmp++; if (vec_s !== mk(1, 0, 0, 0, 0)) begin n_err++; $display("FAIL ovf_clear got %h want %h", vec_s, mk(1, 0, 0, 0, 0)); end
        apply(0, 0, 0, 0, 1); tick();
    endtask

    task automatic test_overrun();
        apply(1, 0, 1, 9, 1); tick();
        apply(0, 1, 0, 0, 0); tick();
        n_cmp++; if (vec_s !== mk(1, 9, 1, 0, 0)) begin n_err++; $display("FAIL ovr_first got %h want %h", vec_s, mk(1, 9, 1, 0, 0)); end
        apply(0, 1, 1, 6, 0);
        n_cmp++; if (in_ready_s !== 1'b0) begin n_err++; $display("FAIL ovr_stall got %b want 0", in_ready_s); end
        tick();
        n_cmp++; if (vec_s !== mk(1, 9, 1, 0, 1)) begin n_err++; $display("FAIL ovr_pulse got %h want %h", vec_s, mk(1, 9, 1, 0, 1)); end
        apply(0, 0, 0, 0, 0); tick();
        n_cmp++; if (vec_s !== mk(1, 9, 1, 0, 0)) begin n_err++; $display("FAIL ovr_hold got %h want %h", vec_s, mk(1, 9, 1, 0, 0)); end
        n_cmp++; if (in_ready_s !== 1'b0) begin n_err++; $display("FAIL ovr_stall2 got %b want 0", in_ready_s); end
        apply(0, 0, 0, 0, 1);
        n_cmp++; if (in_ready_s !== 1'b1) begin n_err++; $display("FAIL ovr_release got %b want 1", in_ready_s); end
        tick();
    endtask

    task automatic test_same_cycle();
        apply(1, 0, 1, 20, 1); tick();
        apply(1, 1, 1, 7, 1); tick();
        n_cmp++; if (vec_s !== mk(1, 20, 1, 0, 0)) begin n_err++; $display("FAIL same_commit got %h want %h", vec_s, mk(1, 20, 1, 0, 0)); end
        apply(0, 1, 0, 0, 1); tick();
        n_cmp++; if (vec_s !== mk(1, 7, 1, 0, 0)) begin n_err++; $display("FAIL same_live got %h want %h", vec_s, mk(1, 7, 1, 0, 0)); end
        apply(0, 0, 0, 0, 1); tick();
    endtask

    task automatic test_cnt_sat();
        apply(1, 0, 0, 0, 1); tick();
        for (int i = 0; i < 18; i++) begin apply(0, 0, 1, 1, 1); tick(); end
        apply(0, 1, 0, 0, 1); tick();
        n_cmp++; if (vec_w !== mk(1, 18, 15, 0, 0)) begin n_err++; $display("FAIL cnt_sat got %h want %h", vec_w, mk(1, 18, 15, 0, 0)); end
        apply(0, 0, 0, 0, 1); tick();
    endtask

    task automatic test_back_to_back();
        apply(0, 0, 0, 0, 1); rst = 1'b1; tick();
        for (int k = 0; k < 24; k++) begin
            apply((k % 4) == 1, (k % 4) == 0, 1, 1, 1);
            tick();
            n_cmp++; if (vec_s !== exp_vec(0) || ovr_s !== 1'b0) begin n_err++; $display("FAIL b2b_model k=%0d got %h want %h", k, vec_s, exp_vec(0)); end
            if ((k % 4) == 0 && k >= 4) begin
                n_cmp++; if (cnt_s !== 4'd3 || acc_s !== 8'd3 || out_valid_s !== 1'b1) begin n_err++; $display("FAIL b2b_cnt k=%0d got cnt=%0d acc=%0d want 3/3", k, cnt_s, acc_s); end
            end
        end
    endtask

    task automatic test_random();
        apply(0, 0, 0, 0, 1); rst = 1'b1; tick();
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 79) == 0);
            #0;
            n_cmp++; if (in_ready_s !== !(mfull && !out_ready) || in_ready_w !== in_ready_s) begin n_err++; $display("FAIL rnd_in_ready i=%0d got %b/%b want %b", i, in_ready_s, in_ready_w, !(mfull && !out_ready)); end
            tick();
            n_cmp++; if (vec_s !== exp_vec(0)) begin n_err++; $display("FAIL rnd_sat i=%0d got %h want %h", i, vec_s, exp_vec(0)); end
            n_cmp++; if (vec_w !== exp_vec(1)) begin n_err++; $display("FAIL rnd_wrap i=%0d got %h want %h", i, vec_w, exp_vec(1)); end
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_ovf();
        test_overrun();
        test_same_cycle();
        test_cnt_sat();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
